ysyx_22050598_if_stage: RTL

Instruction-fetch stage of the ysyx_22050598 pipeline, directly upstream of the IF/ID pipeline register. It owns the architectural fetch PC, issues one instruction-memory request at a time over a valid/ready request channel, and accepts the response over a valid-only response channel. It presents {pc, inst, valid} to IF/ID and substitutes a NOP bubble whenever no correct-path instruction is available. PC redirects from branches, jumps and traps squash in-flight and held fetches.

---
 rtl/ysyx_22050598_if_stage.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22050598_if_stage.sv
// ---------------------------------------------------------------------------
// ysyx_22050598_if_stage
//
// Instruction-fetch stage. It owns the fetch PC and keeps at most one
// instruction-memory request outstanding. It presents {pc, inst, valid} to
// the IF/ID register, and presents a NOP bubble whenever no correct-path
// instruction is available. A redirect squashes any in-flight or held fetch.
//
// Optional feature macro: YSYX_22050598_IF_BYPASS_EN
//   defined   : a live response with no stall is presented in the same cycle
//               it arrives (combinational memory-to-decode path).
//   undefined : every live response goes through hold_inst and is presented
//               one cycle later (default build).
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   if_stall          IF/ID is not capturing this cycle
//   redirect_valid/pc PC redirect (target bits [1:0] forced to 0)
//   imem_req_*        request channel (valid/ready), word-aligned address
//   imem_resp_*       response channel (valid only)
//   if_pc_o/inst_o/valid_o  presented instruction to IF/ID
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | first cycle after reset, no request
// REQ   | request valid on imem_req_*, waiting for ready
// WAIT  | request accepted, waiting for response (kill = drop it)
// HOLD  | live instruction held in hold_inst until IF/ID captures it
// ---------------------------------------------------------------------------
module ysyx_22050598_if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [63:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [63:0] fetch_pc_q,  fetch_pc_d;
    logic        kill_q,      kill_d;
    logic [31:0] hold_inst_q, hold_inst_d;

    logic [63:0] redirect_tgt;
    logic [63:0] pc_plus4;
    logic        handshake;
    logic        live_resp;

    assign redirect_tgt = {redirect_pc[63:2], 2'b00};
    assign pc_plus4     = fetch_pc_q + 64'd4;
    assign handshake    = (state_q == S_REQ) && imem_req_ready;
    assign live_resp    = (state_q == S_WAIT) && imem_resp_valid && !kill_q;

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = fetch_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            kill_q      <= 1'b0;
            hold_inst_q <= NOP_INST;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            kill_q      <= kill_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    // Next-state logic. Redirect is checked first in every state so that it
    // overrides handshakes, responses and held instructions.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        kill_d      = kill_q;
        hold_inst_d = hold_inst_q;

        unique case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_tgt;
                end
                state_d = S_REQ;
            end

            S_REQ: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_tgt;
                    // An already-accepted request targets the old PC; its
                    // response must be discarded when it returns.
                    if (handshake) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (handshake) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_tgt;
                    if (imem_resp_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
`ifdef YSYX_22050598_IF_BYPASS_EN
                        if (if_stall) begin
                            hold_inst_d = imem_resp_data;
                            state_d     = S_HOLD;
                        end else begin
                            fetch_pc_d  = pc_plus4;
                            state_d     = S_REQ;
                        end
`else
                        hold_inst_d = imem_resp_data;
                        state_d     = S_HOLD;
`endif
                    end
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_tgt;
                    state_d    = S_REQ;
                end else if (!if_stall) begin
                    fetch_pc_d = pc_plus4;
                    state_d    = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Presentation to IF/ID. A redirect cycle always shows a bubble because
    // whatever is available belongs to the squashed path.
    always_comb begin
        if_valid_o = 1'b0;
        if_pc_o    = 64'd0;
        if_inst_o  = NOP_INST;
        if (!redirect_valid) begin
            if (state_q == S_HOLD) begin
                if_valid_o = 1'b1;
                if_pc_o    = fetch_pc_q;
                if_inst_o  = hold_inst_q;
            end
`ifdef YSYX_22050598_IF_BYPASS_EN
            else if (live_resp && !if_stall) begin
                if_valid_o = 1'b1;
                if_pc_o    = fetch_pc_q;
                if_inst_o  = imem_resp_data;
            end
`endif
        end
    end

`ifndef YSYX_22050598_IF_BYPASS_EN
    // Only the bypass path consumes live_resp.
    logic unused_live_resp;
    assign unused_live_resp = live_resp;
`endif

endmodule
